truth_table_sweeper: RTL and testbench

- Sequential stimulus/capture stage that sits directly upstream of the 4-input combinational function blocks (SoP/PoS implementations of f(a,b,c,d)).
- On a start pulse it drives every input vector 0..2^N_IN-1 onto {a,b,c,d} in ascending order and waits a settle interval for each vector.
- It then samples the SoP and PoS results and builds the captured truth table, a per-minterm SoP/PoS mismatch mask and a minterm count.
- Replaces hand-written exhaustive testbench sweeps with a reusable hardware sweeper.

---
 rtl/truth_table_sweeper_if.sv | 27 ++
 rtl/truth_table_sweeper.sv | 110 +++++++++++
 tb/tb_truth_table_sweeper.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_if.sv
// Bundle between the truth-table sweeper and whoever starts it and owns the
// function under test. The master starts sweeps and supplies the function
// outputs. The slave, which is the sweeper, drives the vector and the results.
interface truth_table_sweeper_if #(
   parameter int N_IN = 4
);
   logic                     start;
   logic [N_IN-1:0]          vec_out;
   logic                     s_sop;
   logic                     s_pos;
   logic                     busy;
   logic                     done;
   logic [(1 << N_IN)-1:0]   table_sop;
   logic [(1 << N_IN)-1:0]   mismatch_mask;
   logic                     mismatch;
   logic [N_IN:0]            minterm_count;

   modport master (
      output start, s_sop, s_pos,
      input  vec_out, busy, done, table_sop, mismatch_mask, mismatch, minterm_count
   );

   modport slave (
      input  start, s_sop, s_pos,
      output vec_out, busy, done, table_sop, mismatch_mask, mismatch, minterm_count
   );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus/capture stage for a small combinational function.
// A start request walks vec_out through every input vector in ascending order.
// Each vector is held for SETTLE cycles and then sampled for one cycle.
// The sweep builds the SoP truth table, the SoP/PoS disagreement mask and the
// minterm count.
module truth_table_sweeper #(
   parameter int N_IN   = 4,
   parameter int SETTLE = 1
) (
   input logic                   clk,
   input logic                   rst_n,
   truth_table_sweeper_if.slave  bus
);
   localparam int              NVEC        = 1 << N_IN;
   localparam logic [N_IN-1:0] VEC_LAST    = {N_IN{1'b1}};
   localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [N_IN-1:0]   vec_q, vec_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [NVEC-1:0]   table_q, table_d;
   logic [NVEC-1:0]   mask_q, mask_d;
   logic              mismatch_q, mismatch_d;
   logic [N_IN:0]     count_q, count_d;

   // Next-state and result update: hold everything unless the current state says otherwise
   always_comb begin
      state_d    = state_q;
      vec_d      = vec_q;
      cnt_d      = cnt_q;
      table_d    = table_q;
      mask_d     = mask_q;
      mismatch_d = mismatch_q;
      count_d    = count_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               vec_d   = '0;
               cnt_d   = '0;
               table_d = '0;
               mask_d  = '0;
               count_d = '0;
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d   = '0;
               state_d = S_SAMPLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_SAMPLE: begin
            table_d[vec_q] = bus.s_sop;
            mask_d[vec_q]  = bus.s_sop ^ bus.s_pos;
            count_d        = count_q + (N_IN + 1)'(bus.s_sop);
            if (vec_q == VEC_LAST) begin
               state_d = S_DONE;
            end else begin
               vec_d   = vec_q + N_IN'(1);
               state_d = S_SETTLE;
            end
         end
         S_DONE: begin
            mismatch_d = |mask_q;
            state_d    = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and result registers; reset aborts any sweep in progress and wipes the results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         vec_q      <= '0;
         cnt_q      <= '0;
         table_q    <= '0;
         mask_q     <= '0;
         mismatch_q <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         vec_q      <= vec_d;
         cnt_q      <= cnt_d;
         table_q    <= table_d;
         mask_q     <= mask_d;
         mismatch_q <= mismatch_d;
         count_q    <= count_d;
      end
   end

   assign bus.vec_out       = vec_q;
   assign bus.busy          = (state_q != S_IDLE);
   assign bus.done          = (state_q == S_DONE);
   assign bus.table_sop     = table_q;
   assign bus.mismatch_mask = mask_q;
   assign bus.mismatch      = mismatch_q;
   assign bus.minterm_count = count_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper.
// Two sweepers share clock, reset and start. One uses SETTLE=1 and the other
// uses SETTLE=3. Both are checked every cycle against a closed-form timing
// model of the sweep.
module tb_truth_table_sweeper;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] fsop;
   logic [15:0] fpos;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   truth_table_sweeper_if #(.N_IN(4)) sw1 ();
   truth_table_sweeper_if #(.N_IN(4)) sw3 ();

   assign sw1.start = start;
   assign sw3.start = start;
   assign sw1.s_sop = fsop[sw1.vec_out];
   assign sw1.s_pos = fpos[sw1.vec_out];
   assign sw3.s_sop = fsop[sw3.vec_out];
   assign sw3.s_pos = fpos[sw3.vec_out];

   truth_table_sweeper #(.N_IN(4), .SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(sw1.slave));
   truth_table_sweeper #(.N_IN(4), .SETTLE(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(sw3.slave));

   logic [3:0]  obs_vec  [2];
   logic        obs_busy [2];
   logic        obs_done [2];
   logic        obs_mism [2];
   logic [15:0] obs_tab  [2];
   logic [15:0] obs_mask [2];
   logic [4:0]  obs_cnt  [2];

   assign obs_vec[0]  = sw1.vec_out;
   assign obs_busy[0] = sw1.busy;
   assign obs_done[0] = sw1.done;
   assign obs_mism[0] = sw1.mismatch;
   assign obs_tab[0]  = sw1.table_sop;
   assign obs_mask[0] = sw1.mismatch_mask;
   assign obs_cnt[0]  = sw1.minterm_count;
   assign obs_vec[1]  = sw3.vec_out;
   assign obs_busy[1] = sw3.busy;
   assign obs_done[1] = sw3.done;
   assign obs_mism[1] = sw3.mismatch;
   assign obs_tab[1]  = sw3.table_sop;
   assign obs_mask[1] = sw3.mismatch_mask;
   assign obs_cnt[1]  = sw3.minterm_count;

   typedef struct packed {
      logic [3:0]  vec;
      logic        busy;
      logic        done;
      logic        mism;
      logic [15:0] tab;
      logic [15:0] mask;
      logic [4:0]  cnt;
   } exp_t;

   // Model state per sweeper: accepted-start edge plus snapshot of the function under test
   bit          has      [2];
   int          start_at [2];
   logic [15:0] snap_sop [2];
   logic [15:0] snap_pos [2];
   logic        mism_prev[2];

   int done_at   [2];
   int done_count[2];

   function automatic int settle_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   // Expected outputs after edge c, derived from elapsed time since the accepted start
   function automatic exp_t model_at(input int k, input int c);
      exp_t        e;
      int          s1, len, t, n_sampled;
      logic [15:0] low;
      e = '0;
      if (!has[k]) return e;
      s1  = settle_of(k) + 1;
      len = 16 * s1;
      t   = c - start_at[k];
      if (t < len) begin
         n_sampled = t / s1;
         e.vec  = 4'(n_sampled);
         e.busy = 1'b1;
         e.mism = mism_prev[k];
      end else begin
         n_sampled = 16;
         e.vec  = 4'hF;
         e.busy = (t == len);
         e.done = (t == len);
         e.mism = (t == len) ? mism_prev[k] : |(snap_sop[k] ^ snap_pos[k]);
      end
      low    = (n_sampled >= 16) ? 16'hFFFF : 16'((32'd1 << n_sampled) - 32'd1);
      e.tab  = snap_sop[k] & low;
      e.mask = (snap_sop[k] ^ snap_pos[k]) & low;
      e.cnt  = 5'($countones(snap_sop[k] & low));
      return e;
   endfunction

   // Model clock: a start is taken when the sweeper has been back in IDLE for a full cycle
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) has[k] <= 1'b0;
      end else begin
         cyc <= cyc + 1;
         for (int k = 0; k < 2; k++) begin
            if (start && (!has[k] || (cyc + 1 - start_at[k]) >= 16 * (settle_of(k) + 1) + 2)) begin
               has[k]       <= 1'b1;
               start_at[k]  <= cyc + 1;
               snap_sop[k]  <= fsop;
               snap_pos[k]  <= fpos;
               mism_prev[k] <= model_at(k, cyc).mism;
            end
         end
      end
   end

   task automatic check_value(input string name, input int k, input logic [15:0] act,
                              input logic [15:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("[TB] FAIL %s dut%0d cyc=%0d actual=%h required=%h", name, k, cyc, act, req);
      end
   endtask

   // Compare every sweeper output against the model on each falling edge
   always @(negedge clk) begin
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         e = model_at(k, cyc);
         check_value("busy", k, 16'(obs_busy[k]), 16'(e.busy));
         check_value("done", k, 16'(obs_done[k]), 16'(e.done));
         check_value("vec_out", k, 16'(obs_vec[k]), 16'(e.vec));
         check_value("table_sop", k, obs_tab[k], e.tab);
         check_value("mismatch_mask", k, obs_mask[k], e.mask);
         check_value("minterm_count", k, 16'(obs_cnt[k]), 16'(e.cnt));
         if (!e.busy) check_value("mismatch", k, 16'(obs_mism[k]), 16'(e.mism));
      end
   end

   // Record when each sweeper signals completion
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (obs_done[k] === 1'b1) begin
            done_at[k]    <= cyc;
            done_count[k] <= done_count[k] + 1;
         end
      end
   end

   task automatic pulse_start(output int e);
      @(posedge clk);
      #1;
      start = 1'b1;
      e = cyc + 1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int n;
      for (n = 0; n < bound; n++) begin
         @(negedge clk);
         if (obs_busy[0] === 1'b0 && obs_busy[1] === 1'b0) break;
      end
      n_checks++;
      if (n >= bound) begin
         n_errors++;
         $display("[TB] FAIL wait_idle timeout actual=busy required=idle within %0d cycles", bound);
      end
   endtask

   task automatic wait_vec(input logic [3:0] v, input int bound);
      int n;
      for (n = 0; n < bound; n++) begin
         @(negedge clk);
         if (obs_vec[0] === v) break;
      end
      n_checks++;
      if (n >= bound) begin
         n_errors++;
         $display("[TB] FAIL wait_vec timeout actual=%h required=%h", obs_vec[0], v);
      end
   endtask

   task automatic apply_stimulus();
      int len;
      fsop = 16'($urandom);
      fpos = fsop ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk);
      #1;
      start = 1'b1;
      len = $urandom_range(1, 3);
      repeat (len) @(posedge clk);
      #1;
      start = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
         repeat ($urandom_range(2, 20)) @(posedge clk);
         #1;
         start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      wait_idle(300);
   endtask

   initial begin
      int e;
      int c0;
      rst_n = 1'b0;
      start = 1'b0;
      fsop  = 16'h0000;
      fpos  = 16'h0000;
      for (int k = 0; k < 2; k++) begin
         done_at[k]    = 0;
         done_count[k] = 0;
      end
      #12;
      rst_n = 1'b1;
      @(negedge clk);
      check_value("reset_vec", 0, 16'(obs_vec[0]), 16'h0);
      check_value("reset_busy", 0, 16'(obs_busy[0]), 16'h0);
      check_value("reset_table", 0, obs_tab[0], 16'h0);
      check_value("reset_count", 0, 16'(obs_cnt[0]), 16'h0);

      // Reference function, with PoS agreeing with SoP
      fsop = 16'h5363;
      fpos = 16'h5363;
      pulse_start(e);
      wait_idle(200);
      check_value("s1_done_time", 0, 16'(done_at[0]), 16'(e + 32));
      check_value("s1_done_time", 1, 16'(done_at[1]), 16'(e + 64));
      check_value("s1_table", 0, obs_tab[0], 16'h5363);
      check_value("s1_mask", 0, obs_mask[0], 16'h0000);
      check_value("s1_mismatch", 0, 16'(obs_mism[0]), 16'h0);
      check_value("s1_count", 0, 16'(obs_cnt[0]), 16'd8);
      check_value("s1_table", 1, obs_tab[1], 16'h5363);
      check_value("s1_count", 1, 16'(obs_cnt[1]), 16'd8);

      // PoS tied low: every minterm becomes a disagreement
      fpos = 16'h0000;
      pulse_start(e);
      wait_idle(200);
      check_value("s2_mask", 0, obs_mask[0], 16'h5363);
      check_value("s2_mismatch", 0, 16'(obs_mism[0]), 16'h1);
      check_value("s2_count", 0, 16'(obs_cnt[0]), 16'd8);
      check_value("s2_mask", 1, obs_mask[1], 16'h5363);

      // Asynchronous reset in the middle of a sweep
      fpos = 16'h5363;
      pulse_start(e);
      wait_vec(4'd7, 100);
      c0 = done_count[0];
      #2;
      rst_n = 1'b0;
      #1;
      check_value("async_vec", 0, 16'(obs_vec[0]), 16'h0);
      check_value("async_busy", 0, 16'(obs_busy[0]), 16'h0);
      check_value("async_table", 0, obs_tab[0], 16'h0);
      check_value("async_mismatch", 0, 16'(obs_mism[0]), 16'h0);
      check_value("async_busy", 1, 16'(obs_busy[1]), 16'h0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check_value("async_no_done", 0, 16'(done_count[0]), 16'(c0));
      pulse_start(e);
      wait_idle(200);
      check_value("restart_done_time", 0, 16'(done_at[0]), 16'(e + 32));
      check_value("restart_table", 0, obs_tab[0], 16'h5363);

      // A start while busy is ignored
      c0 = done_count[0];
      pulse_start(e);
      wait_vec(4'd5, 100);
      @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_idle(200);
      check_value("repulse_done_time", 0, 16'(done_at[0]), 16'(e + 32));
      check_value("repulse_done_count", 0, 16'(done_count[0]), 16'(c0 + 1));

      // Start held high: back-to-back sweeps separated by one IDLE cycle
      c0 = done_count[0];
      @(posedge clk);
      #1;
      start = 1'b1;
      repeat (110) @(negedge clk);
      check_value("held_done_count", 0, 16'(done_count[0]), 16'(c0 + 3));
      start = 1'b0;
      wait_idle(300);

      // Random functions with sparse SoP/PoS disagreements
      for (int i = 0; i < 25; i++) apply_stimulus();

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
